mem_bus_sequencer: RTL
======================

Name: mem_bus_sequencer

Overview:
- Controller that time-shares the memory address/data buses between instruction fetch (PC) and data load/store (transfer register).
- Drives PC/TX address-assert enables, memory OE/WE, instruction dispatch gating, PC tick and pipeline cancel.
- Replaces the hard-wired PC assert, tied-off WE and constant-zero pipeline cancel in the processor top level.

Parameters:
DELAY_RISE, 0, output rise delay (gate model)
DELAY_FALL, 0, output fall delay (gate model)
READ_WAIT_CYCLES, 0, extra access cycles for data reads (0..14)
WRITE_PULSE_CYCLES, 1, WE_bar low width in cycles (1..15)
FLUSH_CYCLES, 2, cycles PIPELINE_CANCEL is held after a branch (1..15; equals pipeline depth)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset, asynchronous, active-high
FETCH_EN  input  1  permit instruction fetch
HALT  input  1  halt request from pipeline stage 2
DATA_REQ  input  1  data access request; held by requester until DATA_ACK
DATA_WRITE  input  1  1=store, 0=load; sampled with DATA_REQ
BRANCH  input  1  taken-branch pulse from stage 2
PC_ASSERT_bar  output  1  PC drives address bus (active low)
TX_ASSERT_ADDR_bar  output  1  transfer reg drives address bus (active low)
MEM_OE_bar  output  1  memory output enable (active low)
MEM_WE_bar  output  1  memory write enable (active low)
DISPATCH_bar  output  1  0 = dispatch fetched byte to pipeline; 1 = insert 0x00 bubble
PC_TICK  output  1  increment PC this cycle
PIPELINE_CANCEL  output  1  cancel in-flight pipeline stages
STALL  output  1  fetch suspended for data access
DATA_ACK  output  1  one-cycle pulse: data access complete
STATE  output  3  current state, for display

Behaviour:
- Moore machine; all outputs decoded from registered state, change only after CLK rising edge (or RST).
- States: IDLE=0, FETCH=1, DATA_SETUP=2, DATA_ACCESS=3, DATA_RECOVER=4, FLUSH=5; 6,7 illegal -> IDLE.
- RST high: immediately state=IDLE, counter=0, pending-branch=0, latched write=0.
- Exactly one of PC_ASSERT_bar/TX_ASSERT_ADDR_bar low in every state; address bus never floats.
- MEM_OE_bar and MEM_WE_bar never both low.
- IDLE: PC_ASSERT_bar=0, TX=1, OE_bar=0, WE_bar=1, DISPATCH_bar=1, PC_TICK=0, CANCEL=0, STALL=0, DATA_ACK=0. Next: FETCH if FETCH_EN & !HALT.
- FETCH: PC assert, OE_bar=0, DISPATCH_bar=0, PC_TICK=1. Priority: BRANCH -> FLUSH; else HALT -> IDLE; else DATA_REQ -> DATA_SETUP (latch DATA_WRITE); else !FETCH_EN -> IDLE; else stay.
- DATA_SETUP (1 cycle): TX assert, PC deasserted, WE_bar=1, OE_bar=latched write, DISPATCH_bar=1, PC_TICK=0, STALL=1. Load counter: WRITE_PULSE_CYCLES (write) or READ_WAIT_CYCLES+1 (read). -> DATA_ACCESS.
- DATA_ACCESS: TX assert, STALL=1; write: WE_bar=0, OE_bar=1; read: OE_bar=0. Counter decrements each cycle; at counter==1 -> DATA_RECOVER.
- DATA_RECOVER (1 cycle): TX assert, WE_bar=1, OE_bar=latched write, STALL=1, DATA_ACK=1. Next: pending-branch -> FLUSH; else HALT -> IDLE; else FETCH.
- Data cycle length = READ_WAIT_CYCLES+3 (read) or WRITE_PULSE_CYCLES+2 (write).
- BRANCH in DATA_* states: sets pending-branch; cleared on entry to FLUSH.
- DATA_REQ in DATA_RECOVER ignored; FETCH always occupies >=1 cycle between data accesses.
- FLUSH: PC assert, OE_bar=0, PIPELINE_CANCEL=1, DISPATCH_bar=1, PC_TICK=0. Counter loaded FLUSH_CYCLES on entry; BRANCH in FLUSH reloads. At counter==1: HALT seen during flush -> IDLE, else FETCH.
- Counter 4 bits; out-of-range parameters are an elaboration error.

Test Plan:
- Assert RST mid-DATA_ACCESS with WE_bar low -> same timestep WE_bar=1, PC_ASSERT_bar=0, TX_ASSERT_ADDR_bar=1, STATE=0, DATA_ACK never pulses.
- Release RST, FETCH_EN=1 for 6 cycles -> 1 cycle IDLE, then PC_TICK=1 and DISPATCH_bar=0 for 5 consecutive cycles.
- READ_WAIT_CYCLES=1, DATA_REQ=1, DATA_WRITE=0 in FETCH -> STATE 2,3,3,4; STALL=1 and PC_ASSERT_bar=1 for 4 cycles; DATA_ACK on 4th cycle only; then FETCH.
- WRITE_PULSE_CYCLES=2 store -> WE_bar low exactly 2 cycles; TX_ASSERT_ADDR_bar low 1 cycle before and after; OE_bar=1 throughout.
- FLUSH_CYCLES=2: BRANCH in FETCH -> PIPELINE_CANCEL=1 for 2 cycles, PC_TICK=0; BRANCH during DATA_ACCESS -> CANCEL starts the cycle after DATA_ACK.
- HALT with DATA_REQ in FETCH -> IDLE, no data cycle; BRANCH with HALT -> 2 FLUSH cycles, then IDLE.

Source files
------------

// File: rtl/mem_bus_sequencer.sv
// Memory bus sequencer: time-shares the address/data buses between instruction
// fetch (PC) and data load/store (transfer register) as a registered Moore FSM.
module mem_bus_sequencer #(
  parameter int DELAY_RISE         = 0,
  parameter int DELAY_FALL         = 0,
  parameter int READ_WAIT_CYCLES   = 0,
  parameter int WRITE_PULSE_CYCLES = 1,
  parameter int FLUSH_CYCLES       = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FETCH_EN,
  input  logic       HALT,
  input  logic       DATA_REQ,
  input  logic       DATA_WRITE,
  input  logic       BRANCH,
  output logic       PC_ASSERT_bar,
  output logic       TX_ASSERT_ADDR_bar,
  output logic       MEM_OE_bar,
  output logic       MEM_WE_bar,
  output logic       DISPATCH_bar,
  output logic       PC_TICK,
  output logic       PIPELINE_CANCEL,
  output logic       STALL,
  output logic       DATA_ACK,
  output logic [2:0] STATE
);

  // Delays belong to the gate model only; they just have to be sane here.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("mem_bus_sequencer: negative output delay");
  end
  if (READ_WAIT_CYCLES < 0 || READ_WAIT_CYCLES > 14) begin : g_bad_read_wait
    $error("mem_bus_sequencer: READ_WAIT_CYCLES must be 0..14");
  end
  if (WRITE_PULSE_CYCLES < 1 || WRITE_PULSE_CYCLES > 15) begin : g_bad_write_pulse
    $error("mem_bus_sequencer: WRITE_PULSE_CYCLES must be 1..15");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("mem_bus_sequencer: FLUSH_CYCLES must be 1..15");
  end

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT_CYCLES + 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_PULSE_CYCLES);
  localparam logic [3:0] FL_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_FETCH        = 3'd1,
    S_DATA_SETUP   = 3'd2,
    S_DATA_ACCESS  = 3'd3,
    S_DATA_RECOVER = 3'd4,
    S_FLUSH        = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;   // branch taken while the bus was busy with data
  logic       wr_q, wr_d;       // latched DATA_WRITE of the current access
  logic       halt_q, halt_d;   // HALT observed while flushing

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    halt_d  = halt_q;
    case (state_q)
      S_IDLE: begin
        if (FETCH_EN && !HALT) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (BRANCH) begin
          state_d = S_FLUSH;
          cnt_d   = FL_LOAD;
          halt_d  = HALT;
          pend_d  = 1'b0;
        end else if (HALT) begin
          state_d = S_IDLE;
        end else if (DATA_REQ) begin
          state_d = S_DATA_SETUP;
          wr_d    = DATA_WRITE;
        end else if (!FETCH_EN) begin
          state_d = S_IDLE;
        end
      end
      S_DATA_SETUP: begin
        state_d = S_DATA_ACCESS;
        cnt_d   = wr_q ? WR_LOAD : RD_LOAD;
        if (BRANCH) pend_d = 1'b1;
      end
      S_DATA_ACCESS: begin
        if (BRANCH) pend_d = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DATA_RECOVER;
      end
      S_DATA_RECOVER: begin
        // A branch arriving in this last cycle must not be lost.
        if (pend_q || BRANCH) begin
          state_d = S_FLUSH;
          cnt_d   = FL_LOAD;
          halt_d  = HALT;
          pend_d  = 1'b0;
        end else if (HALT) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FLUSH: begin
        halt_d = halt_q | HALT;
        if (BRANCH) begin
          cnt_d = FL_LOAD;
        end else if (cnt_q == 4'd1) begin
          state_d = (halt_q || HALT) ? S_IDLE : S_FETCH;
          halt_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        pend_d  = 1'b0;
        halt_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    PC_ASSERT_bar      = 1'b0;
    TX_ASSERT_ADDR_bar = 1'b1;
    MEM_OE_bar         = 1'b0;
    MEM_WE_bar         = 1'b1;
    DISPATCH_bar       = 1'b1;
    PC_TICK            = 1'b0;
    PIPELINE_CANCEL    = 1'b0;
    STALL              = 1'b0;
    DATA_ACK           = 1'b0;
    case (state_q)
      S_FETCH: begin
        DISPATCH_bar = 1'b0;
        PC_TICK      = 1'b1;
      end
      S_DATA_SETUP: begin
        PC_ASSERT_bar      = 1'b1;
        TX_ASSERT_ADDR_bar = 1'b0;
        MEM_OE_bar         = wr_q;
        STALL              = 1'b1;
      end
      S_DATA_ACCESS: begin
        PC_ASSERT_bar      = 1'b1;
        TX_ASSERT_ADDR_bar = 1'b0;
        MEM_OE_bar         = wr_q;
        MEM_WE_bar         = !wr_q;
        STALL              = 1'b1;
      end
      S_DATA_RECOVER: begin
        PC_ASSERT_bar      = 1'b1;
        TX_ASSERT_ADDR_bar = 1'b0;
        MEM_OE_bar         = wr_q;
        STALL              = 1'b1;
        DATA_ACK           = 1'b1;
      end
      S_FLUSH: begin
        PIPELINE_CANCEL = 1'b1;
      end
      default: ;
    endcase
  end

  assign STATE = state_q;

endmodule
